des_sbox_engine: RTL and testbench

Parametrised DES substitution stage that takes the 48-bit expanded, key-mixed round value and produces the 32-bit S-box output. It evaluates all eight standard DES S-boxes (S1–S8, FIPS 46-3 tables), `LANES` at a time, so area can be traded against throughput. It sits between the round key-XOR and the P-permutation stage of the round datapath, with valid/ready handshakes on both sides.

---
 rtl/des_sbox_engine_if.sv | 21 ++
 rtl/des_sbox_engine.sv | 132 +++++++++++++
 tb/tb_des_sbox_engine.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_sbox_engine_if.sv
// Handshake bundle for the DES S-box stage: input block side and result side.
interface des_sbox_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  // Producer/consumer view: drives blocks in, takes results out.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Engine view.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/des_sbox_engine.sv
// DES substitution stage: 48-bit key-mixed value in, 32-bit S1..S8 result out.
// LANES S-boxes are evaluated per clock; one block takes 8/LANES busy cycles.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// BUSY  | evaluating one group of LANES S-boxes per cycle, S1 group first
// DONE  | result presented; accepting a new block here overlaps with output
module des_sbox_engine #(
  parameter int LANES = 8
) (
  input logic             clk,
  input logic             reset_n,
  des_sbox_engine_if.slave bus
);

  localparam int N_GROUPS = 8 / LANES;
  localparam int GW       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(N_GROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [47:0]     blk;
  logic [31:0]     acc;
  logic [GW-1:0]   grp;
  logic            out_valid_q;
  logic            idle_q;
  logic [31:0]     acc_next;
  logic [2:0]      sel;

  // Each table is 64 nibbles, row-major (row = {b5,b0}, column = b4..b1),
  // entry 0 in the most significant nibble.
  function automatic logic [255:0] sbox_rom(input logic [2:0] n);
    logic [255:0] rom;
    case (n)
      3'd0: rom = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                   64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
      3'd1: rom = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                   64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
      3'd2: rom = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                   64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
      3'd3: rom = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                   64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
      3'd4: rom = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                   64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
      3'd5: rom = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                   64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
      3'd6: rom = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                   64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
      default: rom = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                      64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
    endcase
    return rom;
  endfunction

  function automatic logic [3:0] sbox_lookup(input logic [2:0] n, input logic [5:0] x);
    logic [255:0] rom;
    logic [5:0]   idx;
    idx = {x[5], x[0], x[4:1]};
    rom = sbox_rom(n) << {idx, 2'b00};
    return rom[255:252];
  endfunction

  // Merge the current group's S-box results into the accumulator; other nibbles hold.
  always_comb begin
    acc_next = acc;
    sel      = '0;
    for (int l = 0; l < LANES; l++) begin
      sel = 3'(int'(grp) * LANES + l);
      acc_next[4*(7 - int'(sel)) +: 4] = sbox_lookup(sel, blk[6*(7 - int'(sel)) +: 6]);
    end
  end

  // Control FSM plus datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grp         <= '0;
      blk         <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            blk    <= bus.in_data;
            grp    <= '0;
            idle_q <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          grp <= grp + GW'(1);
          if (grp == LAST_GRP) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              blk   <= bus.in_data;
              grp   <= '0;
              state <= BUSY;
            end else begin
              idle_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          idle_q      <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  // In DONE a new block can be taken on the same edge that the result leaves.
  assign bus.in_ready  = idle_q | (out_valid_q & bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc;

endmodule

// File: tb/tb_des_sbox_engine.sv
// Bench for des_sbox_engine: one instance per LANES value (1, 2, 4, 8),
// checked against a table-driven model of the DES S-box function.
module tb_des_sbox_engine;

  logic        clk;
  logic        reset_n;
  logic [3:0]  in_v;
  logic [47:0] in_d [4];
  logic [3:0]  out_r;
  logic [3:0]  in_r;
  logic [3:0]  out_v;
  logic [31:0] out_d [4];

  int tests;
  int fails;

  // Instance g has LANES = 1 << g.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    des_sbox_engine_if u_if ();
    assign u_if.in_valid  = in_v[g];
    assign u_if.in_data   = in_d[g];
    assign u_if.out_ready = out_r[g];
    assign in_r[g]        = u_if.in_ready;
    assign out_v[g]       = u_if.out_valid;
    assign out_d[g]       = u_if.out_data;
    des_sbox_engine #(.LANES(1 << g)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (u_if)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIPS 46-3 S-boxes, [box][row][column].
  int sbox_tab [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  function automatic logic [31:0] ref_sbox(input logic [47:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      int v, row, col;
      v   = int'((x >> (42 - 6 * i)) & 48'h3F);
      row = (v / 32) * 2 + (v % 2);
      col = (v / 2) % 16;
      r   = r | (32'(sbox_tab[i][row][col]) << (28 - 4 * i));
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    logic [47:0] r;
    r[31:0]  = $urandom;
    r[47:32] = 16'($urandom);
    return r;
  endfunction

  // Drive one block into lane k from a negedge, wait for the result, pop it.
  // lat = cycles from the accepting edge to out_valid, -1 on timeout.
  task automatic run_block(input int k, input logic [47:0] d, output logic [31:0] res,
                           output int lat, output int busy_bad);
    int w;
    res = '0; lat = 0; busy_bad = 0; w = 0;
    in_v[k] = 1'b1; in_d[k] = d; out_r[k] = 1'b0;
    #1;
    while (!in_r[k] && w < 20) begin @(negedge clk); #1; w++; end
    if (!in_r[k]) begin in_v[k] = 1'b0; lat = -1; return; end
    @(posedge clk);
    @(negedge clk);
    in_v[k] = 1'b0;
    in_d[k] = rand48();
    while (!out_v[k] && lat < 20) begin
      if (in_r[k]) busy_bad++;
      @(negedge clk);
      lat++;
    end
    if (!out_v[k]) begin lat = -1; return; end
    res = out_d[k];
    out_r[k] = 1'b1;
    @(negedge clk);
    out_r[k] = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (in_r[k] !== 1'b1) begin fails++; $display("FAIL reset_in_ready lane%0d got=%b exp=1", k, in_r[k]); end
      tests++;
      if (out_v[k] !== 1'b0) begin fails++; $display("FAIL reset_out_valid lane%0d got=%b exp=0", k, out_v[k]); end
      tests++;
      if (out_d[k] !== 32'h0) begin fails++; $display("FAIL reset_out_data lane%0d got=%h exp=0", k, out_d[k]); end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_zero;
    logic [31:0] res; int lat, bad;
    run_block(3, 48'h0, res, lat, bad);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    tests++;
    if (res !== 32'hEFA72C4D) begin fails++; $display("FAIL zero_data got=%h exp=efa72c4d", res); end
  endtask

  task automatic test_ones;
    logic [31:0] res; int lat, bad;
    run_block(0, 48'hFFFF_FFFF_FFFF, res, lat, bad);
    tests++;
    if (lat !== 8) begin fails++; $display("FAIL ones_latency got=%0d exp=8", lat); end
    tests++;
    if (res !== 32'hD9CE3DCB) begin fails++; $display("FAIL ones_data got=%h exp=d9ce3dcb", res); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL ones_busy_in_ready got=%0d cycles high exp=0", bad); end
  endtask

  task automatic test_table;
    logic [31:0] res, exp; logic [47:0] d; int lat, bad;
    for (int k = 0; k < 4; k++) begin
      for (int f = 0; f < 8; f++) begin
        for (int v = 0; v < 64; v++) begin
          d = 48'(v) << (42 - 6 * f);
          exp = ref_sbox(d);
          run_block(k, d, res, lat, bad);
          tests++;
          if (res !== exp || lat != (8 >> k) || bad != 0) begin
            fails++;
            $display("FAIL table lane%0d in=%h got=%h lat=%0d busy_rdy=%0d exp=%h lat=%0d busy_rdy=0",
                     k, d, res, lat, bad, exp, 8 >> k);
          end
        end
      end
    end
  endtask

  // Streams n random blocks; with bp, out_ready toggles randomly, otherwise
  // both handshakes stay asserted and the accept spacing is checked.
  task automatic test_stream(input int k, input int n, input bit bp);
    logic [31:0] q [$];
    logic [31:0] exp, prev_od;
    logic [47:0] d;
    int cyc, accepted, last_acc, budget;
    bit hold;
    cyc = 0; accepted = 0; last_acc = -1; hold = 1'b0; prev_od = '0;
    budget = 40 * n + 100;
    while ((accepted < n || q.size() > 0) && cyc < budget) begin
      if (hold) begin
        tests++;
        if (out_v[k] !== 1'b1 || out_d[k] !== prev_od) begin
          fails++;
          $display("FAIL hold lane%0d got v=%b d=%h exp v=1 d=%h", k, out_v[k], out_d[k], prev_od);
        end
      end
      d = rand48();
      in_v[k]  = (accepted < n);
      in_d[k]  = d;
      out_r[k] = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (out_v[k] && out_r[k]) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra lane%0d got=%h exp=no output", k, out_d[k]);
        end else begin
          exp = q.pop_front();
          if (out_d[k] !== exp) begin
            fails++;
            $display("FAIL stream_data lane%0d got=%h exp=%h", k, out_d[k], exp);
          end
        end
      end
      hold = out_v[k] && !out_r[k];
      prev_od = out_d[k];
      if (in_v[k] && in_r[k]) begin
        q.push_back(ref_sbox(d));
        if (!bp && last_acc >= 0) begin
          tests++;
          if (cyc - last_acc != (8 >> k) + 1) begin
            fails++;
            $display("FAIL b2b_interval lane%0d got=%0d exp=%0d", k, cyc - last_acc, (8 >> k) + 1);
          end
        end
        last_acc = cyc;
        accepted++;
      end
      @(negedge clk);
      cyc++;
    end
    in_v[k] = 1'b0;
    out_r[k] = 1'b0;
    tests++;
    if (accepted != n || q.size() != 0) begin
      fails++;
      $display("FAIL stream_timeout lane%0d got accepted=%0d pending=%0d exp accepted=%0d pending=0",
               k, accepted, q.size(), n);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) test_stream(k, 50, 1'b0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) test_stream(k, 1000, 1'b1);
  endtask

  task automatic test_backpressure;
    localparam int K = 2;
    logic [47:0] d1, d2;
    int w, lat;
    d1 = rand48(); d2 = rand48();
    w = 0; lat = 0;
    in_v[K] = 1'b1; in_d[K] = d1; out_r[K] = 1'b0;
    #1;
    while (!in_r[K] && w < 20) begin @(negedge clk); #1; w++; end
    @(posedge clk);
    @(negedge clk);
    in_v[K] = 1'b0;
    w = 0;
    while (!out_v[K] && w < 20) begin @(negedge clk); w++; end
    in_v[K] = 1'b1; in_d[K] = d2;
    for (int c = 0; c < 20; c++) begin
      #1;
      tests++;
      if (out_v[K] !== 1'b1 || out_d[K] !== ref_sbox(d1) || in_r[K] !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cyc%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0",
                 c, out_v[K], out_d[K], in_r[K], ref_sbox(d1));
      end
      @(negedge clk);
    end
    out_r[K] = 1'b1;
    #1;
    tests++;
    if (in_r[K] !== 1'b1) begin fails++; $display("FAIL bp_release_ready got=%b exp=1", in_r[K]); end
    @(posedge clk);
    @(negedge clk);
    in_v[K] = 1'b0; out_r[K] = 1'b0;
    tests++;
    if (out_v[K] !== 1'b0) begin fails++; $display("FAIL bp_popped got=%b exp=0", out_v[K]); end
    while (!out_v[K] && lat < 20) begin @(negedge clk); lat++; end
    tests++;
    if (lat != 2 || out_d[K] !== ref_sbox(d2)) begin
      fails++;
      $display("FAIL bp_next got=%h lat=%0d exp=%h lat=2", out_d[K], lat, ref_sbox(d2));
    end
    out_r[K] = 1'b1;
    @(negedge clk);
    out_r[K] = 1'b0;
  endtask

  task automatic test_reset_mid;
    localparam int K = 1;
    logic [31:0] res; int lat, bad, w;
    w = 0;
    in_v[K] = 1'b1; in_d[K] = 48'hFFFF_FFFF_FFFF; out_r[K] = 1'b0;
    #1;
    while (!in_r[K] && w < 20) begin @(negedge clk); #1; w++; end
    @(posedge clk);
    in_v[K] = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (out_v[K] !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got=%b exp=0", out_v[K]); end
    tests++;
    if (out_d[K] !== 32'h0) begin fails++; $display("FAIL midrst_out_data got=%h exp=0", out_d[K]); end
    tests++;
    if (in_r[K] !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got=%b exp=1", in_r[K]); end
    @(negedge clk);
    reset_n = 1'b1;
    run_block(K, 48'hFFFF_FFFF_FFFF, res, lat, bad);
    tests++;
    if (lat != 4 || res !== 32'hD9CE3DCB) begin
      fails++;
      $display("FAIL midrst_next got=%h lat=%0d exp=d9ce3dcb lat=4", res, lat);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0;
    in_v = '0; out_r = '0;
    for (int k = 0; k < 4; k++) in_d[k] = '0;
    test_reset();
    test_zero();
    test_ones();
    test_table();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=time limit reached exp=bench completion");
    $fatal(1, "watchdog");
  end

endmodule
